rgb_frame_monitor: RTL and testbench

Parametrised successor to the single-frame RGB pixel-stream checker: registers an RGB stream, tracks the (x, y) raster position of every valid beat, and emits line/frame completion pulses. Supports configurable resolution, channel width and multi-frame runs, with an explicit stop/re-arm state machine. Flags and counts stray beats arriving after the run has completed, and optionally produces per-frame per-channel checksums. Sits on the pixclk side of the VFP bench, between the D5M/VFP stream sources and the scoreboard/log writers.

---
 rtl/rgb_frame_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_rgb_frame_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_monitor.sv
// RGB pixel-stream monitor: registers the stream, tracks raster position, pulses on line/frame end,
// stops after NUM_FRAMES and counts stray beats. Optional per-frame checksums via RGB_MON_CHECKSUM_EN.
module rgb_frame_monitor #(
   parameter  int IMG_WIDTH  = 400,
   parameter  int IMG_HEIGHT = 300,
   parameter  int DATA_W     = 8,
   parameter  int NUM_FRAMES = 1,
   localparam int XW         = $clog2(IMG_WIDTH),
   localparam int YW         = $clog2(IMG_HEIGHT),
   localparam int SW         = DATA_W + $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic              pixclk,
   input  logic              reset,
   input  logic              valid,
   input  logic [DATA_W-1:0] iRed,
   input  logic [DATA_W-1:0] iGreen,
   input  logic [DATA_W-1:0] iBlue,
   input  logic              rearm,
   output logic              oValid,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic [XW-1:0]     x_coord,
   output logic [YW-1:0]     y_coord,
   output logic              line_done,
   output logic              frame_done,
   output logic              sim_done,
   output logic [15:0]       frame_count,
   output logic              err_overrun,
   output logic [15:0]       err_count,
   output logic [SW-1:0]     sum_red,
   output logic [SW-1:0]     sum_green,
   output logic [SW-1:0]     sum_blue
);

   // state   | meaning
   // ST_RUN  | counting beats into frames
   // ST_DONE | run complete; beats are overruns until rearm
   typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              ovalid_q, ovalid_d;
   logic [DATA_W-1:0] ored_q, ored_d, ogreen_q, ogreen_d, oblue_q, oblue_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              line_q, line_d, frame_q, frame_d;
   logic [15:0]       fcnt_q, fcnt_d, ecnt_q, ecnt_d;
   logic              err_q, err_d;
   logic              run_beat, last_x, last_y, frame_end;

   assign run_beat  = (state_q == ST_RUN) && ovalid_q;
   assign last_x    = (x_q == XW'(IMG_WIDTH - 1));
   assign last_y    = (y_q == YW'(IMG_HEIGHT - 1));
   assign frame_end = run_beat && last_x && last_y;

   always_comb begin
      ovalid_d = valid;
      ored_d   = iRed;
      ogreen_d = iGreen;
      oblue_d  = iBlue;
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      line_d   = 1'b0;
      frame_d  = 1'b0;
      fcnt_d   = fcnt_q;
      err_d    = err_q;
      ecnt_d   = ecnt_q;
      case (state_q)
         ST_RUN: begin
            if (ovalid_q) begin
               if (last_x) begin
                  x_d    = '0;
                  line_d = 1'b1;
                  if (last_y) begin
                     y_d     = '0;
                     frame_d = 1'b1;
                     fcnt_d  = fcnt_q + 16'd1;
                     if ((NUM_FRAMES != 0) && (fcnt_d == 16'(NUM_FRAMES)))
                        state_d = ST_DONE;
                  end else begin
                     y_d = y_q + YW'(1);
                  end
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         ST_DONE: begin
            x_d = '0;
            y_d = '0;
            // a beat arriving together with rearm is still an overrun
            if (ovalid_q) begin
               err_d = 1'b1;
               if (ecnt_q != 16'hFFFF)
                  ecnt_d = ecnt_q + 16'd1;
            end
            if (rearm) begin
               state_d = ST_RUN;
               fcnt_d  = '0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge pixclk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         ovalid_q <= 1'b0;
         ored_q   <= '0;
         ogreen_q <= '0;
         oblue_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
         fcnt_q   <= '0;
         err_q    <= 1'b0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         ovalid_q <= ovalid_d;
         ored_q   <= ored_d;
         ogreen_q <= ogreen_d;
         oblue_q  <= oblue_d;
         x_q      <= x_d;
         y_q      <= y_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         fcnt_q   <= fcnt_d;
         err_q    <= err_d;
         ecnt_q   <= ecnt_d;
      end
   end

`ifdef RGB_MON_CHECKSUM_EN
   logic [SW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
   logic [SW-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;

   always_comb begin
      acc_r_d = acc_r_q;
      acc_g_d = acc_g_q;
      acc_b_d = acc_b_q;
      sum_r_d = sum_r_q;
      sum_g_d = sum_g_q;
      sum_b_d = sum_b_q;
      if (frame_end) begin
         sum_r_d = acc_r_q + SW'(ored_q);
         sum_g_d = acc_g_q + SW'(ogreen_q);
         sum_b_d = acc_b_q + SW'(oblue_q);
         acc_r_d = '0;
         acc_g_d = '0;
         acc_b_d = '0;
      end else if (run_beat) begin
         acc_r_d = acc_r_q + SW'(ored_q);
         acc_g_d = acc_g_q + SW'(ogreen_q);
         acc_b_d = acc_b_q + SW'(oblue_q);
      end else if ((state_q == ST_DONE) && rearm) begin
         acc_r_d = '0;
         acc_g_d = '0;
         acc_b_d = '0;
      end
   end

   always_ff @(posedge pixclk) begin
      if (reset) begin
         acc_r_q <= '0;
         acc_g_q <= '0;
         acc_b_q <= '0;
         sum_r_q <= '0;
         sum_g_q <= '0;
         sum_b_q <= '0;
      end else begin
         acc_r_q <= acc_r_d;
         acc_g_q <= acc_g_d;
         acc_b_q <= acc_b_d;
         sum_r_q <= sum_r_d;
         sum_g_q <= sum_g_d;
         sum_b_q <= sum_b_d;
      end
   end

   assign sum_red   = sum_r_q;
   assign sum_green = sum_g_q;
   assign sum_blue  = sum_b_q;
`else
   assign sum_red   = '0;
   assign sum_green = '0;
   assign sum_blue  = '0;
`endif

   assign oValid      = ovalid_q;
   assign oRed        = ored_q;
   assign oGreen      = ogreen_q;
   assign oBlue       = oblue_q;
   assign x_coord     = x_q;
   assign y_coord     = y_q;
   assign line_done   = line_q;
   assign frame_done  = frame_q;
   assign sim_done    = (state_q == ST_DONE);
   assign frame_count = fcnt_q;
   assign err_overrun = err_q;
   assign err_count   = ecnt_q;

endmodule

// File: tb/tb_rgb_frame_monitor.sv
// Scoreboard bench: two monitors (run-forever and single-frame) share one randomized stream;
// expectations come from a pixel-index reference model, compared by a negedge monitor.
module tb_rgb_frame_monitor;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int DW = 8;
   localparam int SW = DW + $clog2(W * H);

   typedef struct {
      bit ov; int r; int g; int b; int x; int y;
      bit ld; bit fd; bit sd; int fc; bit eo; int ec;
      int sr; int sg; int sb;
   } exp_t;

   logic          pixclk = 1'b0;
   logic          reset, valid, rearm;
   logic [DW-1:0] iRed, iGreen, iBlue;

   logic          ov [2];
   logic [DW-1:0] or_ [2], og_ [2], ob_ [2];
   logic [1:0]    xc [2];
   logic          yc [2];
   logic          ld [2], fd [2], sd [2], eo [2];
   logic [15:0]   fc [2], ec [2];
   logic [SW-1:0] sr [2], sg [2], sb [2];

   int n_tests = 0;
   int n_fail  = 0;
   exp_t q [2][$];

   // model state per instance: instance 0 runs forever, instance 1 stops after one frame
   bit m_run [2];
   int m_pix [2], m_frames [2], m_ec [2];
   bit m_eo [2], m_ov [2];
   int m_d [2][3], m_acc [2][3], m_sum [2][3];

   always #5 pixclk = ~pixclk;

   rgb_frame_monitor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW), .NUM_FRAMES(0)) dut0 (
      .pixclk(pixclk), .reset(reset), .valid(valid), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .rearm(rearm), .oValid(ov[0]), .oRed(or_[0]), .oGreen(og_[0]), .oBlue(ob_[0]),
      .x_coord(xc[0]), .y_coord(yc[0]), .line_done(ld[0]), .frame_done(fd[0]), .sim_done(sd[0]),
      .frame_count(fc[0]), .err_overrun(eo[0]), .err_count(ec[0]),
      .sum_red(sr[0]), .sum_green(sg[0]), .sum_blue(sb[0]));

   rgb_frame_monitor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW), .NUM_FRAMES(1)) dut1 (
      .pixclk(pixclk), .reset(reset), .valid(valid), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .rearm(rearm), .oValid(ov[1]), .oRed(or_[1]), .oGreen(og_[1]), .oBlue(ob_[1]),
      .x_coord(xc[1]), .y_coord(yc[1]), .line_done(ld[1]), .frame_done(fd[1]), .sim_done(sd[1]),
      .frame_count(fc[1]), .err_overrun(eo[1]), .err_count(ec[1]),
      .sum_red(sr[1]), .sum_green(sg[1]), .sum_blue(sb[1]));

   function automatic void model_step(int k, int nf, bit rst, bit v, int r, int g, int b, bit ra,
                                      output exp_t e);
      e.ld = 0;
      e.fd = 0;
      if (rst) begin
         m_run[k] = 1; m_pix[k] = 0; m_frames[k] = 0; m_ec[k] = 0; m_eo[k] = 0;
         for (int c = 0; c < 3; c++) begin
            m_acc[k][c] = 0; m_sum[k][c] = 0; m_d[k][c] = 0;
         end
         m_ov[k] = 0;
      end else begin
         if (m_run[k]) begin
            if (m_ov[k]) begin
               if (m_pix[k] % W == W - 1) e.ld = 1;
               if (m_pix[k] == W * H - 1) begin
                  e.fd = 1;
                  m_frames[k] = (m_frames[k] + 1) % 65536;
`ifdef RGB_MON_CHECKSUM_EN
                  for (int c = 0; c < 3; c++) m_sum[k][c] = m_acc[k][c] + m_d[k][c];
`endif
                  for (int c = 0; c < 3; c++) m_acc[k][c] = 0;
                  m_pix[k] = 0;
                  if (nf != 0 && m_frames[k] == nf) m_run[k] = 0;
               end else begin
                  m_pix[k]++;
                  for (int c = 0; c < 3; c++) m_acc[k][c] += m_d[k][c];
               end
            end
         end else begin
            if (m_ov[k]) begin
               m_eo[k] = 1;
               if (m_ec[k] < 65535) m_ec[k]++;
            end
            if (ra) begin
               m_run[k] = 1;
               m_frames[k] = 0;
               for (int c = 0; c < 3; c++) m_acc[k][c] = 0;
            end
         end
         m_ov[k] = v;
         m_d[k][0] = r; m_d[k][1] = g; m_d[k][2] = b;
      end
      e.ov = m_ov[k]; e.r = m_d[k][0]; e.g = m_d[k][1]; e.b = m_d[k][2];
      e.x  = m_run[k] ? m_pix[k] % W : 0;
      e.y  = m_run[k] ? m_pix[k] / W : 0;
      e.sd = !m_run[k];
      e.fc = m_frames[k]; e.eo = m_eo[k]; e.ec = m_ec[k];
      e.sr = m_sum[k][0]; e.sg = m_sum[k][1]; e.sb = m_sum[k][2];
   endfunction

   function automatic void chk(int k, string nm, logic [63:0] act, logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL dut%0d %s at %0t: got %0h expected %0h", k, nm, $time, act, exp_v);
      end
   endfunction

   always @(negedge pixclk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (q[k].size() > 0) begin
            e = q[k].pop_front();
            chk(k, "oValid", 64'(ov[k]), 64'(e.ov));
            chk(k, "oRed", 64'(or_[k]), 64'(e.r));
            chk(k, "oGreen", 64'(og_[k]), 64'(e.g));
            chk(k, "oBlue", 64'(ob_[k]), 64'(e.b));
            chk(k, "x_coord", 64'(xc[k]), 64'(e.x));
            chk(k, "y_coord", 64'(yc[k]), 64'(e.y));
            chk(k, "line_done", 64'(ld[k]), 64'(e.ld));
            chk(k, "frame_done", 64'(fd[k]), 64'(e.fd));
            chk(k, "sim_done", 64'(sd[k]), 64'(e.sd));
            chk(k, "frame_count", 64'(fc[k]), 64'(e.fc));
            chk(k, "err_overrun", 64'(eo[k]), 64'(e.eo));
            chk(k, "err_count", 64'(ec[k]), 64'(e.ec));
            chk(k, "sum_red", 64'(sr[k]), 64'(e.sr));
            chk(k, "sum_green", 64'(sg[k]), 64'(e.sg));
            chk(k, "sum_blue", 64'(sb[k]), 64'(e.sb));
         end
      end
   end

   task automatic cyc(bit rst, bit v, int r, int g, int b, bit ra);
      exp_t e;
      reset = rst; valid = v; rearm = ra;
      iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b);
      @(posedge pixclk);
      model_step(0, 0, rst, v, r, g, b, ra, e);
      q[0].push_back(e);
      model_step(1, 1, rst, v, r, g, b, ra, e);
      q[1].push_back(e);
      #1;
   endtask

   task automatic rcyc(bit rst, bit v, bit ra);
      cyc(rst, v, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)), ra);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; rearm = 1'b0;
      iRed = '0; iGreen = '0; iBlue = '0;
      #1;
      repeat (3) rcyc(1, 0, 0);
      for (int i = 0; i < 8; i++) rcyc(0, 1, 0);
      repeat (3) rcyc(0, 0, 0);
      for (int i = 0; i < 3; i++) rcyc(0, 1, 0);
      repeat (2) rcyc(0, 0, 0);
      rcyc(0, 0, 1);
      for (int i = 0; i < 16; i++) rcyc(0, (i % 2) == 0, 0);
      repeat (2) rcyc(0, 0, 0);
      rcyc(0, 1, 0);
      rcyc(0, 0, 1);
      repeat (2) rcyc(0, 0, 0);
      rcyc(1, 0, 0);
      for (int i = 0; i < 24; i++) rcyc(0, 1, 0);
      repeat (2) rcyc(0, 0, 0);
      rcyc(1, 0, 0);
      for (int i = 0; i < 5; i++) rcyc(0, 1, 0);
      rcyc(1, 1, 0);
      for (int i = 0; i < 8; i++) rcyc(0, 1, 0);
      repeat (2) rcyc(0, 0, 0);
      rcyc(1, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, i + 1, 255, 0, 0);
      repeat (3) rcyc(0, 0, 0);
      for (int i = 0; i < 400; i++)
         rcyc($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 10);
      repeat (3) rcyc(0, 0, 0);
      repeat (2) @(negedge pixclk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
